// File: rtl/octal_rr_arbiter.sv
// Round-robin arbiter for 8 requesters with registered binary and one-hot grant outputs.
// Each tenure ends on done, on the owner dropping its request, or after MAX_HOLD cycles.
module octal_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       done,
    output logic       grant_valid,
    output logic [2:0] grant_idx,
    output logic [7:0] grant_onehot
);

    localparam int unsigned HW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_e;

    state_e          state_q, state_d;
    logic [2:0]      ptr_q, ptr_d;
    logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
    logic            grant_valid_q, grant_valid_d;
    logic [2:0]      grant_idx_q, grant_idx_d;
    logic [7:0]      grant_onehot_q, grant_onehot_d;

    logic [2:0]      winner;
    logic            any_req;
    logic            timeout;
    logic            release_grant;

    // Scan from the farthest offset down so the bit closest to ptr wins last.
    always_comb begin
        winner  = ptr_q;
        any_req = |req;
        for (int unsigned i = 8; i > 0; i--) begin
            if (req[ptr_q + 3'(i - 1)]) begin
                winner = ptr_q + 3'(i - 1);
            end
        end
    end

    always_comb begin
        timeout       = (MAX_HOLD != 0) && (hold_cnt_q == HW'(MAX_HOLD - 1));
        release_grant = done || !req[grant_idx_q] || timeout;
    end

    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        hold_cnt_d     = hold_cnt_q;
        grant_valid_d  = grant_valid_q;
        grant_idx_d    = grant_idx_q;
        grant_onehot_d = grant_onehot_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d        = GRANT;
                    grant_valid_d  = 1'b1;
                    grant_idx_d    = winner;
                    grant_onehot_d = 8'b1 << winner;
                    hold_cnt_d     = '0;
                end
            end
            GRANT: begin
                if (release_grant) begin
                    state_d        = IDLE;
                    grant_valid_d  = 1'b0;
                    grant_onehot_d = '0;
                    ptr_d          = grant_idx_q + 3'd1;
                end else if (hold_cnt_q != '1) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            ptr_q          <= '0;
            hold_cnt_q     <= '0;
            grant_valid_q  <= 1'b0;
            grant_idx_q    <= '0;
            grant_onehot_q <= '0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            hold_cnt_q     <= hold_cnt_d;
            grant_valid_q  <= grant_valid_d;
            grant_idx_q    <= grant_idx_d;
            grant_onehot_q <= grant_onehot_d;
        end
    end

    assign grant_valid  = grant_valid_q;
    assign grant_idx    = grant_idx_q;
    assign grant_onehot = grant_onehot_q;

endmodule

// File: tb/tb_octal_rr_arbiter.sv
// Bench for octal_rr_arbiter: two instances (MAX_HOLD 4 and 16) against a tenure-level model,
// plus a directed vector table for the MAX_HOLD=4 instance.
module tb_octal_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic       done;

    logic       v4, v16;
    logic [2:0] i4, i16;
    logic [7:0] o4, o16;

    always #5 clk = ~clk;

    octal_rr_arbiter #(.MAX_HOLD(4)) dut4 (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .grant_valid(v4), .grant_idx(i4), .grant_onehot(o4)
    );

    octal_rr_arbiter #(.MAX_HOLD(16)) dut16 (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .grant_valid(v16), .grant_idx(i16), .grant_onehot(o16)
    );

    int tests = 0;
    int fails = 0;

    // Model: owner, how many cycles it has been visible, and where the next search starts.
    bit m_busy[2];
    int m_owner[2];
    int m_held[2];
    int m_start[2];
    int m_max[2] = '{4, 16};

    typedef struct {
        logic       rst;
        logic [7:0] req;
        logic       done;
        logic       v;
        logic [2:0] idx;
        logic [7:0] oh;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic r, input logic [7:0] q, input logic d,
                                input logic v, input int idx, input logic [7:0] oh);
        vec_t e;
        e.rst = r; e.req = q; e.done = d; e.v = v; e.idx = 3'(idx); e.oh = oh;
        tbl.push_back(e);
    endfunction

    function automatic logic [11:0] model_out(input int m);
        logic [7:0] oh;
        oh = m_busy[m] ? (8'd1 << m_owner[m]) : 8'd0;
        return {m_busy[m], 3'(m_owner[m]), oh};
    endfunction

    task automatic model_step(input int m, input logic r, input logic [7:0] q, input logic d);
        if (r) begin
            m_busy[m] = 0; m_owner[m] = 0; m_held[m] = 0; m_start[m] = 0;
        end else if (!m_busy[m]) begin
            for (int k = 0; k < 8; k++) begin
                int c;
                c = (m_start[m] + k) % 8;
                if (q[c]) begin
                    m_busy[m] = 1; m_owner[m] = c; m_held[m] = 1;
                    break;
                end
            end
        end else begin
            if (d || !q[m_owner[m]] || (m_max[m] != 0 && m_held[m] >= m_max[m])) begin
                m_busy[m] = 0;
                m_start[m] = (m_owner[m] + 1) % 8;
            end else begin
                m_held[m]++;
            end
        end
    endtask

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got valid=%0b idx=%0d onehot=%h, expected valid=%0b idx=%0d onehot=%h",
                     name, act[11], act[10:8], act[7:0], exp[11], exp[10:8], exp[7:0]);
        end
    endtask

    task automatic cycle(input logic r, input logic [7:0] q, input logic d);
        @(negedge clk);
        rst = r; req = q; done = d;
        @(posedge clk);
        model_step(0, r, q, d);
        model_step(1, r, q, d);
        #1;
        check("model_hold4", {v4, i4, o4}, model_out(0));
        check("model_hold16", {v16, i16, o16}, model_out(1));
    endtask

    initial begin
        logic [7:0] rq;
        logic [7:0] one;
        rst = 1'b1; req = '0; done = 1'b0;
        one = 8'd1;

        // Reset then quiet
        add(1, 8'h00, 0, 0, 0, 8'h00);
        add(1, 8'h00, 0, 0, 0, 8'h00);
        for (int k = 0; k < 10; k++) add(0, 8'h00, 0, 0, 0, 8'h00);
        // Single requester 5, done on third grant cycle
        add(0, 8'h20, 0, 1, 5, 8'h20);
        add(0, 8'h20, 0, 1, 5, 8'h20);
        add(0, 8'h20, 0, 1, 5, 8'h20);
        add(0, 8'h20, 1, 0, 5, 8'h00);
        add(0, 8'h00, 0, 0, 5, 8'h00);
        // Wrap from ptr=6 to requester 0, then 1
        add(0, 8'h03, 0, 1, 0, 8'h01);
        add(0, 8'h03, 1, 0, 0, 8'h00);
        add(0, 8'h03, 0, 1, 1, 8'h02);
        add(0, 8'h03, 1, 0, 1, 8'h00);
        add(0, 8'h00, 0, 0, 1, 8'h00);
        // Timeout at 4 cycles, then done coinciding with timeout
        add(1, 8'h00, 0, 0, 0, 8'h00);
        for (int k = 0; k < 4; k++) add(0, 8'h06, 0, 1, 1, 8'h02);
        add(0, 8'h06, 0, 0, 1, 8'h00);
        for (int k = 0; k < 4; k++) add(0, 8'h06, 0, 1, 2, 8'h04);
        add(0, 8'h06, 1, 0, 2, 8'h00);
        add(0, 8'h06, 0, 1, 1, 8'h02);
        add(0, 8'h06, 1, 0, 1, 8'h00);
        // Owner drops request, then reset mid-grant of 6
        add(0, 8'h04, 0, 1, 2, 8'h04);
        add(0, 8'h00, 0, 0, 2, 8'h00);
        add(0, 8'h40, 0, 1, 6, 8'h40);
        add(1, 8'h40, 0, 0, 0, 8'h00);
        add(0, 8'hC1, 0, 1, 0, 8'h01);
        add(0, 8'hC1, 1, 0, 0, 8'h00);

        foreach (tbl[k]) begin
            cycle(tbl[k].rst, tbl[k].req, tbl[k].done);
            check($sformatf("table[%0d]", k), {v4, i4, o4}, {tbl[k].v, tbl[k].idx, tbl[k].oh});
        end

        // Fairness with all requesting and a done on every grant cycle
        cycle(1, 8'h00, 0);
        for (int k = 0; k < 9; k++) begin
            cycle(0, 8'hFF, 0);
            check($sformatf("fair_grant[%0d]", k), {v4, i4, o4},
                  {1'b1, 3'(k % 8), one << (k % 8)});
            check($sformatf("fair_grant16[%0d]", k), {v16, i16, o16},
                  {1'b1, 3'(k % 8), one << (k % 8)});
            cycle(0, 8'hFF, 1);
            check($sformatf("fair_gap[%0d]", k), {v4, i4, o4}, {1'b0, 3'(k % 8), 8'h00});
        end

        // Long hold exercising the 16-cycle timeout
        cycle(1, 8'h00, 0);
        for (int k = 0; k < 20; k++) cycle(0, 8'h01, 0);
        check("hold16_released", {v16, i16, o16}, {1'b1, 3'd0, 8'h01});

        // Random traffic with persistent requests
        rq = 8'h00;
        cycle(1, 8'h00, 0);
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(3) == 0) rq = 8'($urandom) & 8'($urandom);
            cycle(($urandom_range(199) == 0), rq, ($urandom_range(7) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
